// File: rtl/channel_in_lane_scatter_if.sv
// channel_in_lane_scatter_if: beat-in / lane-vector-out stream bundle for channel_in_lane_scatter.
// master drives input beats and consumes vectors; slave is the gatherer.
interface channel_in_lane_scatter_if #(
  parameter int N      = 16,
  parameter int LANE_W = 16
);
  logic [LANE_W-1:0]   in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [N*LANE_W-1:0] out_data;
  logic [N-1:0]        out_lane_mask;
  logic                out_valid;
  logic                out_ready;
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_lane_mask, out_valid
  );
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_lane_mask, out_valid
  );
endinterface

// File: rtl/channel_in_lane_scatter.sv
// channel_in_lane_scatter: packs N serial lane words into one lane vector (lane 0 in the LSBs).
// Define CHANNEL_SCATTER_PAD_EN to let in_last close a short, zero-padded group.
module channel_in_lane_scatter #(
  parameter int N      = 16,
  parameter int LANE_W = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  channel_in_lane_scatter_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic {FILL, HOLD} state_e;
  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N-1:0][LANE_W-1:0] gather_q, gather_d, wr_lanes;
  logic [N-1:0][LANE_W-1:0] out_data_q, out_data_d;
  logic [N-1:0]             mask_q, mask_d, cnt_mask;
  logic                     out_valid_q, out_valid_d;
  logic                     accept, complete, out_free;
  assign bus.in_ready      = state_q == FILL;
  assign bus.out_data      = out_data_q;
  assign bus.out_lane_mask = mask_q;
  assign bus.out_valid     = out_valid_q;
  assign accept            = bus.in_valid & bus.in_ready;
  assign out_free          = !out_valid_q | bus.out_ready;
`ifdef CHANNEL_SCATTER_PAD_EN
  assign complete = accept & ((cnt_q == CW'(N - 1)) | bus.in_last);
`else
  assign complete = accept & (cnt_q == CW'(N - 1));
`endif
  // Lanes above cnt are already zero because the gather is cleared on every hand-off.
  always_comb begin
    wr_lanes = gather_q;
    cnt_mask = '0;
    for (int i = 0; i < N; i++) begin
      wr_lanes[i] = (accept && cnt_q == CW'(i)) ? bus.in_data : gather_q[i];
      cnt_mask[i] = CW'(i) <= cnt_q;
    end
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gather_d    = gather_q;
    out_data_d  = out_data_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q & !bus.out_ready;
    if (state_q == HOLD) begin
      if (out_free) begin
        out_data_d  = gather_q;
        mask_d      = cnt_mask;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        gather_d    = '0;
        state_d     = FILL;
      end
    end else if (complete && out_free) begin
      out_data_d  = wr_lanes;
      mask_d      = cnt_mask;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      gather_d    = '0;
    end else if (complete) begin
      gather_d = wr_lanes;
      state_d  = HOLD;
    end else if (accept) begin
      gather_d = wr_lanes;
      cnt_d    = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      gather_q    <= '0;
      out_data_q  <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gather_q    <= gather_d;
      out_data_q  <= out_data_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_channel_in_lane_scatter.sv
// tb_channel_in_lane_scatter: directed + random stimulus against a queue-based grouping model.
module tb_channel_in_lane_scatter;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int VW = N * W;
  typedef struct {
    logic [VW-1:0] d;
    logic [N-1:0]  m;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int vecs = 0;
  int ir_drops = 0;
  logic [W-1:0] part[$];
  vec_t expq[$];
  logic stall_prev = 1'b0;
  logic [VW-1:0] prev_data;
  logic [N-1:0]  prev_mask;
  channel_in_lane_scatter_if #(.N(N), .LANE_W(W)) b();
  channel_in_lane_scatter #(.N(N), .LANE_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Model: completed groups wait in expq; the DUT can hold at most two (output + gather).
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      expq.delete();
      stall_prev = 1'b0;
      chk("rst_in_ready", VW'(b.in_ready), 1);
      chk("rst_out_valid", VW'(b.out_valid), 0);
      chk("rst_out_data", b.out_data, 0);
      chk("rst_mask", VW'(b.out_lane_mask), 0);
    end else begin
      chk("out_valid", VW'(b.out_valid), VW'(expq.size() > 0));
      chk("in_ready", VW'(b.in_ready), VW'(expq.size() < 2));
      if (!b.in_ready) ir_drops++;
      if (b.out_valid && expq.size() > 0) begin
        chk("out_data", b.out_data, expq[0].d);
        chk("out_mask", VW'(b.out_lane_mask), VW'(expq[0].m));
      end
      if (stall_prev) begin
        chk("stall_data", b.out_data, prev_data);
        chk("stall_mask", VW'(b.out_lane_mask), VW'(prev_mask));
      end
      stall_prev = b.out_valid & !b.out_ready;
      prev_data  = b.out_data;
      prev_mask  = b.out_lane_mask;
      if (b.out_valid && b.out_ready && expq.size() > 0) begin
        void'(expq.pop_front());
        vecs++;
      end
      if (b.in_valid && b.in_ready) begin
        logic done;
        part.push_back(b.in_data);
        done = part.size() == N;
`ifdef CHANNEL_SCATTER_PAD_EN
        done = done | b.in_last;
`endif
        if (done) begin
          vec_t v;
          v.d = '0;
          v.m = '0;
          foreach (part[i]) begin
            v.d[i*W +: W] = part[i];
            v.m[i] = 1'b1;
          end
          expq.push_back(v);
          part.delete();
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int n, input logic [W-1:0] base, input int inc, input int last_at);
    for (int i = 0; i < n; i++) begin
      logic hs;
      int t;
      b.in_valid = 1'b1;
      b.in_data  = base + W'(i * inc);
      b.in_last  = (i == last_at);
      t = 0;
      do begin
        @(negedge clk);
        hs = b.in_ready;
        step();
        t++;
      end while (!hs && t < 200);
      if (!hs) chk("send_timeout", 0, 1);
    end
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [VW-1:0] all5;
    logic [VW-1:0] padv;
    int acc;
    int cyc;
    all5 = {16{16'h0005}};
    padv = '0;
    padv[79:0] = 80'h000a_000a_000a_000a_000a;
    b.in_data = '0;
    b.in_valid = 1'b1;
    b.in_last = 1'b0;
    b.out_ready = 1'b1;
    step();
    step();
    b.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    // 16 beats 0..F: one vector, high for exactly one cycle
    send(16, 16'h0, 1, -1);
    chk("t1_valid", VW'(b.out_valid), 1);
    chk("t1_mask", VW'(b.out_lane_mask), VW'(16'hFFFF));
    for (int i = 0; i < N; i++) chk("t1_lane", VW'(b.out_data[i*W +: W]), VW'(i));
    step();
    chk("t1_valid_drop", VW'(b.out_valid), 0);
    // 48 back-to-back beats: three vectors, no stall
    acc = vecs;
    send(48, 16'h40, 1, -1);
    step();
    step();
    chk("t2_vecs", VW'(vecs - acc), 3);
    chk("t2_no_stall", VW'(ir_drops), 0);
    // two full groups under backpressure
    b.out_ready = 1'b0;
    send(32, 16'h100, 1, -1);
    chk("t3_in_ready_low", VW'(b.in_ready), 0);
    chk("t3_lane0", VW'(b.out_data[W-1:0]), VW'(16'h100));
    chk("t3_lane15", VW'(b.out_data[15*W +: W]), VW'(16'h10F));
    step();
    chk("t3_held_lane0", VW'(b.out_data[W-1:0]), VW'(16'h100));
    b.out_ready = 1'b1;
    step();
    chk("t3_second_lane0", VW'(b.out_data[W-1:0]), VW'(16'h110));
    chk("t3_second_valid", VW'(b.out_valid), 1);
    chk("t3_in_ready_back", VW'(b.in_ready), 1);
    step();
    chk("t3_drained", VW'(b.out_valid), 0);
    // short group of five 0xA beats
    send(5, 16'hA, 0, 4);
`ifdef CHANNEL_SCATTER_PAD_EN
    chk("t4_valid", VW'(b.out_valid), 1);
    chk("t4_data", b.out_data, padv);
    chk("t4_mask", VW'(b.out_lane_mask), VW'(16'h001F));
    step();
`else
    step();
    step();
    step();
    chk("t4_no_output", VW'(b.out_valid), 0);
    chk("t4_padv_unused", VW'(b.in_ready), VW'(padv[0] | 1'b1));
`endif
    // reset mid-group discards partial lanes
    send(7, 16'h3, 0, -1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    send(16, 16'h5, 0, -1);
    chk("t5_valid", VW'(b.out_valid), 1);
    chk("t5_data", b.out_data, all5);
    chk("t5_mask", VW'(b.out_lane_mask), VW'(16'hFFFF));
    step();
    // random traffic, 1000 beats
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      b.in_valid  = ($urandom % 4) != 0;
      b.in_data   = W'($urandom);
      b.out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      if (b.in_valid && b.in_ready) acc++;
      step();
      cyc++;
    end
    chk("t6_beats", VW'(acc), 1000);
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    step();
    step();
    step();
    chk("t6_empty", VW'(b.out_valid), 0);
`ifdef CHANNEL_SCATTER_PAD_EN
    chk("total_vecs", VW'(vecs), 70);
`else
    chk("total_vecs", VW'(vecs), 69);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/channel_in_lane_scatter.md
# channel_in_lane_scatter

Serial-to-parallel channel gatherer placed upstream of the channel-input adder tree in the TJPU datapath. It accepts one channel-lane word per beat over a valid/ready stream and packs COMPUTE_CHANNEL_IN_NUM consecutive words into the lane-vector bus the 16-to-1 reduction tree consumes. Lane 0 occupies the least-significant slice. A group is emitted only when complete, or early on an end-of-group marker when padding is compiled in.

## Interface
- COMPUTE_CHANNEL_IN_NUM, 16: lanes per output vector; power of two, 2..64.
- LANE_W, `PICTURE_NUM*`WIDTH_DATA_OUT*2: bits per lane word (from Para.v).
- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  LANE_W  one channel-lane word.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  final beat of a short group (only honoured with padding compiled in).
- in_ready  out  1  block accepts a beat this cycle; = !gfull.
- out_data  out  COMPUTE_CHANNEL_IN_NUM*LANE_W  packed vector; lane i at [(i+1)*LANE_W-1 : i*LANE_W].
- out_lane_mask  out  COMPUTE_CHANNEL_IN_NUM  bit i set when lane i carries real data.
- out_valid  out  1  out_data/out_lane_mask valid; held until accepted.
- out_ready  in  1  downstream accepts vector.

## Operation
- Beat accepted when in_valid & in_ready. Word written into gather lane cnt. cnt increments, 0..N-1.
- The completing beat is the one accepted with cnt==N-1, or with in_last=1 when padding is enabled.
- out_free = !out_valid | out_ready.
- Completing beat with out_free: on the same edge, the output register loads the gather lanes plus the incoming lane. Lanes above the last written lane are 0. The mask sets bits 0..cnt. out_valid=1, cnt=0, gather cleared.
- Completing beat with !out_free: the lane is written and gfull=1. in_ready=0 until the first edge with out_free, when gather moves to the output register, gfull=0, and cnt=0.
- Non-completing beat: the lane is written and cnt++. The output register is unaffected.
- Output handshake: out_valid & out_ready with nothing new loading gives out_valid=0 next cycle. A simultaneous accept and load replaces the vector with no bubble.
- out_data and out_lane_mask are stable while out_valid & !out_ready.
- States: FILL (gfull=0) and HOLD (gfull=1).
  - FILL→HOLD on a completing beat with !out_free.
  - HOLD→FILL on out_free.
- Reset mid-group discards partial lanes. No partial vector is emitted.

## Timing
- Reset values: out_valid=0, out_data=0, out_lane_mask=0, cnt=0, gfull=0. in_ready=1 during and after reset, but no beat is accepted while rst_n=0.
- Latency: completing beat accepted at edge E, with out_free, gives out_valid high after E.
- Throughput: one beat per cycle sustained, one vector per N cycles, when downstream is always ready.
- Backpressure stalls input only after a full gather is pending. Up to N beats are absorbed while one vector waits.
- All outputs are registered except in_ready, which is a direct decode of the gfull flop.

## Configuration
- CHANNEL_SCATTER_PAD_EN defined:
  - in_last terminates a group early.
  - Unfilled lanes are driven 0, and the mask reflects the lanes actually written.
  - in_last at cnt==N-1 behaves exactly as a normal full group.
- Undefined:
  - in_last is ignored.
  - Groups complete only at N beats.
  - out_lane_mask is all ones whenever out_valid=1, and 0 after reset.

## Test plan
- 16 beats of 0x0..0xF (N=16), out_ready=1 → out_valid high for exactly one cycle after the 16th edge, lane i = i, mask=0xFFFF, in_ready stays 1.
- 48 back-to-back beats, out_ready=1 → three vectors, one every 16 cycles, no in_ready deassertion.
- out_ready=0 across two full groups → first vector held stable, in_ready=0 after the 32nd beat; on out_ready=1, second vector appears next cycle and in_ready returns to 1.
- PAD_EN: 5 beats of 0xA with in_last on the 5th → lanes 0..4 = 0xA, lanes 5..15 = 0, mask=0x001F; without PAD_EN the same stimulus produces no output.
- rst_n pulsed low after 7 beats, then 16 beats of 0x5 → single vector of all 0x5, no stale lanes, mask=0xFFFF.
- Random in_valid/out_ready, 1000 beats → output stream equals the input stream grouped by 16 in order, and no vector changes while stalled.
